// File: rtl/acc_seq_pkg.sv
// Shared widths and FSM state encoding for the accumulator operand sequencer.
package acc_seq_pkg;

    localparam int A_W   = 20;
    localparam int B_W   = 18;
    localparam int P_W   = 38;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN,
        HOLD
    } state_t;

endpackage

// File: rtl/acc_operand_seq.sv
// Operand sequencer for a multiply-accumulate slice: feeds A/B terms, drains the pipeline and holds the frame result.
// Optional build macro ACC_SEQ_CNT_EN adds a saturating per-frame beat counter (m_count / m_ovf).
module acc_operand_seq
    import acc_seq_pkg::*;
#(
    parameter int ACC_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [A_W-1:0] s_a,
    input  logic signed [B_W-1:0] s_b,
    input  logic                  s_sub,
    input  logic                  s_last,
    output logic signed [A_W-1:0] a_o,
    output logic signed [B_W-1:0] b_o,
    output logic                  subtract_o,
    output logic                  load_acc_o,
    output logic                  acc_clr_o,
    input  logic signed [P_W-1:0] p_i,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef ACC_SEQ_CNT_EN
    output logic [CNT_W-1:0]      m_count,
    output logic                  m_ovf,
`endif
    output logic signed [P_W-1:0] m_p
);

    // DRAIN counts 0..ACC_LAT; the last value marks the edge where p_i holds the final sum.
    localparam logic [2:0] DRAIN_LAST = 3'(ACC_LAT);

    state_t                r_state;
    logic [2:0]            r_drain;
    logic signed [A_W-1:0] r_a;
    logic signed [B_W-1:0] r_b;
    logic                  r_sub;
    logic                  r_load;
    logic signed [P_W-1:0] r_mp;

    logic w_accept;
    logic w_capture;

    assign w_accept  = (r_state == RUN) && s_valid;
    assign w_capture = (r_state == DRAIN) && (r_drain == DRAIN_LAST);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CLEAR;
            r_drain <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_load  <= 1'b0;
            r_mp    <= '0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                CLEAR: r_state <= RUN;
                RUN: begin
                    if (w_accept) begin
                        r_a    <= s_a;
                        r_b    <= s_b;
                        r_sub  <= s_sub;
                        r_load <= 1'b1;
                        if (s_last) begin
                            r_state <= DRAIN;
                            r_drain <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (w_capture) begin
                        r_mp    <= p_i;
                        r_state <= HOLD;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                HOLD: begin
                    if (m_ready) r_state <= CLEAR;
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

`ifdef ACC_SEQ_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_ovf;
    logic [CNT_W-1:0] r_m_count;
    logic             r_m_ovf;

    // The counter sticks at 255 and the overflow flag records any beat beyond that.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_cnt_ovf <= 1'b0;
            r_m_count <= '0;
            r_m_ovf   <= 1'b0;
        end else begin
            if (r_state == CLEAR) begin
                r_cnt     <= '0;
                r_cnt_ovf <= 1'b0;
            end else if (w_accept) begin
                if (r_cnt == '1) r_cnt_ovf <= 1'b1;
                else             r_cnt     <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_m_count <= r_cnt;
                r_m_ovf   <= r_cnt_ovf;
            end
        end
    end

    assign m_count = r_m_count;
    assign m_ovf   = r_m_ovf;
`endif

    assign s_ready    = (r_state == RUN);
    assign acc_clr_o  = (r_state == CLEAR);
    assign m_valid    = (r_state == HOLD);
    assign a_o        = r_a;
    assign b_o        = r_b;
    assign subtract_o = r_sub;
    assign load_acc_o = r_load;
    assign m_p        = r_mp;

endmodule

// File: tb/tb_acc_operand_seq.sv
// Directed bench for acc_operand_seq paired with a behavioural one-stage accumulator.
module tb_acc_operand_seq;
    import acc_seq_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  s_valid;
    logic                  s_ready;
    logic signed [A_W-1:0] s_a;
    logic signed [B_W-1:0] s_b;
    logic                  s_sub;
    logic                  s_last;
    logic signed [A_W-1:0] a_o;
    logic signed [B_W-1:0] b_o;
    logic                  subtract_o;
    logic                  load_acc_o;
    logic                  acc_clr_o;
    logic signed [P_W-1:0] p_i;
    logic                  m_valid;
    logic                  m_ready;
    logic signed [P_W-1:0] m_p;
`ifdef ACC_SEQ_CNT_EN
    logic [CNT_W-1:0]      m_count;
    logic                  m_ovf;
`endif

    logic signed [P_W-1:0] model_p = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_operand_seq #(.ACC_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a        (s_a),
        .s_b        (s_b),
        .s_sub      (s_sub),
        .s_last     (s_last),
        .a_o        (a_o),
        .b_o        (b_o),
        .subtract_o (subtract_o),
        .load_acc_o (load_acc_o),
        .acc_clr_o  (acc_clr_o),
        .p_i        (p_i),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef ACC_SEQ_CNT_EN
        .m_count    (m_count),
        .m_ovf      (m_ovf),
`endif
        .m_p        (m_p)
    );

    // Behavioural accumulator, one register stage from operands to P.
    always @(posedge clk) begin
        if (acc_clr_o)       model_p <= '0;
        else if (load_acc_o) model_p <= subtract_o ? model_p - a_o * b_o : model_p + a_o * b_o;
    end
    assign p_i = model_p;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic signed [A_W-1:0] a, input logic signed [B_W-1:0] b,
                             input logic sub, input logic last);
        int n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_before_beat", s_ready, 1);
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_sub   = sub;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("load_after_beat", load_acc_o, 1);
        chk("a_o_after_beat", a_o, a);
    endtask

    // Called in the cycle after the last beat; result must appear two cycles later.
    task automatic wait_result();
        int n = 1;
        while (!m_valid && n < 12) begin
            tick();
            n++;
        end
        chk("result_latency", n, 3);
    endtask

    task automatic end_frame();
        m_ready = 1'b1;
        tick();
        chk("clear_after_hs", acc_clr_o, 1);
        chk("mvalid_after_hs", m_valid, 0);
        chk("sready_in_clear", s_ready, 0);
        tick();
        chk("sready_after_clear", s_ready, 1);
    endtask

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_sub   = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        #12;
        chk("rst_acc_clr", acc_clr_o, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_load", load_acc_o, 0);
        chk("rst_m_p", m_p, 0);
        chk("rst_a_o", a_o, 0);
        tick();
        reset = 1'b1;
        chk("first_cycle_clear", acc_clr_o, 1);
        tick();
        chk("run_s_ready", s_ready, 1);
        chk("run_acc_clr", acc_clr_o, 0);

        // Single-beat frame 5*2.
        send_beat(20'sd5, 18'sd2, 1'b0, 1'b1);
        chk("drain_s_ready", s_ready, 0);
        wait_result();
        chk("single_m_p", m_p, 10);
        end_frame();

        // Three-term frame: 10 - 12 - 42.
        send_beat(20'sd5, 18'sd2, 1'b0, 1'b0);
        send_beat(20'sd3, 18'sd4, 1'b1, 1'b0);
        send_beat(-20'sd7, 18'sd6, 1'b0, 1'b1);
        wait_result();
        chk("frame3_m_p", m_p, -44);
`ifdef ACC_SEQ_CNT_EN
        chk("frame3_count", m_count, 3);
        chk("frame3_ovf", m_ovf, 0);
`endif
        end_frame();

        // Same frame with two idle cycles after the first beat.
        send_beat(20'sd5, 18'sd2, 1'b0, 1'b0);
        tick();
        chk("gap1_load", load_acc_o, 0);
        chk("gap1_a_hold", a_o, 5);
        tick();
        chk("gap2_load", load_acc_o, 0);
        chk("gap2_b_hold", b_o, 2);
        send_beat(20'sd3, 18'sd4, 1'b1, 1'b0);
        send_beat(-20'sd7, 18'sd6, 1'b0, 1'b1);
        wait_result();
        chk("gap_m_p", m_p, -44);
        end_frame();

        // Back-pressure: result held for 5 cycles, stray s_valid ignored.
        m_ready = 1'b0;
        send_beat(20'sd7, 18'sd3, 1'b1, 1'b1);
        wait_result();
        chk("bp_m_p", m_p, -21);
        s_valid = 1'b1;
        s_a     = 20'sd99;
        s_b     = 18'sd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_p_stable", m_p, -21);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_no_load", load_acc_o, 0);
            chk("bp_a_hold", a_o, 7);
        end
        s_valid = 1'b0;
        end_frame();

        // Most-negative operands give the largest positive product.
        send_beat(-20'sd524288, -18'sd131072, 1'b0, 1'b1);
        wait_result();
        chk("extreme_m_p", m_p, 64'sd68719476736);
        end_frame();

`ifdef ACC_SEQ_CNT_EN
        for (int i = 0; i < 300; i++) send_beat(20'sd1, 18'sd1, 1'b0, i == 299);
        wait_result();
        chk("long_m_p", m_p, 300);
        chk("long_count", m_count, 255);
        chk("long_ovf", m_ovf, 1);
        end_frame();
`endif

        // Reset asserted mid-frame after two beats.
        send_beat(20'sd4, 18'sd4, 1'b0, 1'b0);
        send_beat(20'sd2, 18'sd2, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_acc_clr", acc_clr_o, 1);
        chk("mid_rst_load", load_acc_o, 0);
        chk("mid_rst_a_o", a_o, 0);
        tick();
        reset = 1'b1;
        chk("post_rst_clear", acc_clr_o, 1);
        chk("post_rst_s_ready0", s_ready, 0);
        tick();
        chk("post_rst_s_ready1", s_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("aborted_no_m_valid", m_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/acc_operand_seq.md
ACC_OPERAND_SEQ -- requirements
Module: acc_operand_seq

Interface
REQ-001 Parameter ACC_LAT, default 1, range 1..4: register latency of the downstream accumulator (operands in to P out).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous assert, active-low.
REQ-004 s_valid / s_ready  input / output  1 / 1  operand-beat handshake; transfer when both high on a rising edge.
REQ-005 s_a / s_b  input  20 / 18  signed operands; s_sub input 1 (1 = subtract term); s_last input 1 (final term of frame).
REQ-006 a_o / b_o  output  20 / 18  signed operands to accumulator; subtract_o output 1; load_acc_o output 1 (1 = accumulate, 0 = hold P).
REQ-007 acc_clr_o  output  1  active-high synchronous clear to accumulator.
REQ-008 p_i  input  38  signed accumulator result.
REQ-009 m_valid / m_ready  output / input  1 / 1  result handshake; m_p output 38, signed frame result.

Function
REQ-010 FSM states CLEAR, RUN, DRAIN, HOLD; reset enters CLEAR.
REQ-011 CLEAR lasts exactly one cycle: acc_clr_o=1, s_ready=0, load_acc_o=0; then RUN.
REQ-012 RUN: s_ready=1, acc_clr_o=0; s_ready is decoded from state only, with no dependence on s_valid.
REQ-013 Accepted beat at cycle t: a_o, b_o, subtract_o take s_a, s_b, s_sub and load_acc_o=1 during t+1 (all registered).
REQ-014 RUN cycle without a transfer: load_acc_o=0 next cycle; a_o/b_o/subtract_o hold their last values.
REQ-015 Accepted beat with s_last=1: state goes to DRAIN; s_ready=0 for the rest of the frame.
REQ-016 DRAIN lasts ACC_LAT+1 cycles with load_acc_o=0 after the last term; p_i is sampled into m_p on the final DRAIN edge.
REQ-017 With ACC_LAT=1, the last beat accepted at t gives m_valid=1 from t+3.
REQ-018 HOLD: m_valid=1; m_p stable until the m_valid&&m_ready edge, then CLEAR; m_valid=0 in all other states.
REQ-019 s_valid while s_ready=0 is ignored; the beat is not consumed and no error is raised.
REQ-020 A single-beat frame (s_last on the first beat) is legal.
REQ-021 No arithmetic in this block; p_i is passed unchanged (no truncation or saturation).

Reset
REQ-022 reset low, at any time including mid-frame or mid-HOLD: a_o=0, b_o=0, subtract_o=0, load_acc_o=0, m_valid=0, m_p=0, state=CLEAR (so acc_clr_o=1, s_ready=0).
REQ-023 First cycle after reset release is CLEAR; the pending frame is discarded.

Configuration
REQ-024 Macro ACC_SEQ_CNT_EN.
REQ-025 Defined: adds output m_count (8 bits, number of accepted beats in the frame, saturating at 255) and m_ovf (1 = more than 255 beats); both are captured with m_p, and the counter clears in CLEAR.
REQ-026 Undefined: m_count, m_ovf and the counter logic are absent; all other behaviour is identical.

Structure
REQ-027 Shared package acc_seq_pkg: A_W=20, B_W=18, P_W=38, CNT_W=8, the FSM state enum.
REQ-028 Single module; no sub-module is warranted.

Verification
Bench pairs the DUT with a behavioural accumulator: P<=0 on clr; P<=P±A*B when load; latency ACC_LAT.
REQ-029 Reset pulled low mid-frame (two beats accepted) -> immediately s_ready=0, m_valid=0, acc_clr_o=1, load_acc_o=0; after release one CLEAR cycle, then s_ready=1; no m_valid is produced for the aborted frame.
REQ-030 Single beat A=5, B=2, sub=0, last=1 accepted at t -> m_p=10, m_valid=1 at t+3.
REQ-031 Frame (5,2,+), (3,4,-), (-7,6,+,last) -> m_p=-44; defined ACC_SEQ_CNT_EN -> m_count=3, m_ovf=0.
REQ-032 Same frame with s_valid low two cycles between beats 1 and 2 -> load_acc_o=0 in those cycles, m_p=-44.
REQ-033 m_ready held low 5 cycles -> m_valid=1, m_p constant, s_ready=0 throughout; after the handshake, one CLEAR cycle then s_ready=1.
REQ-034 Beat A=-524288, B=-131072 (last) -> m_p=68719476736; defined ACC_SEQ_CNT_EN with 300-beat frame of (1,1,+) -> m_p=300, m_count=255, m_ovf=1.
